// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Optional flags output enabled with `define ALU_SEQ_FLAGS_EN; otherwise flags are tied to 3'b000.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         command,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               oe,
  output logic [2*WIDTH-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic [2:0]         flags
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_INC, OP_SUB, OP_DEC, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
    OP_AND, OP_OR, OP_INV, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_BUF
  } op_t;

  localparam int unsigned           CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]         LAST = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0]    ONE  = (2*WIDTH)'(1);

  state_t             state;
  op_t                op_r;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc, result;
  logic [WIDTH-1:0]   mplier, rem, quot;

  logic [2*WIDTH-1:0] za, zb, alu_res, mul_acc_nxt, res_nxt;
  logic [WIDTH:0]     div_shift;
  logic               div_ge, last;
  logic [WIDTH-1:0]   rem_nxt, quot_nxt;

  assign za = {{WIDTH{1'b0}}, a_r};
  assign zb = {{WIDTH{1'b0}}, b_r};

  always_comb begin
    alu_res = '0;
    case (op_r)
      OP_ADD:  alu_res = za + zb;
      OP_INC:  alu_res = za + ONE;
      OP_SUB:  alu_res = za - zb;
      OP_DEC:  alu_res = za - ONE;
      OP_SHL:  alu_res = za << 2;
      OP_SHR:  alu_res = za >> 2;
      OP_AND:  alu_res = za & zb;
      OP_OR:   alu_res = za | zb;
      OP_INV:  alu_res = ~za;
      OP_NAND: alu_res = ~(za & zb);
      OP_NOR:  alu_res = ~(za | zb);
      OP_XOR:  alu_res = za ^ zb;
      OP_XNOR: alu_res = ~(za ^ zb);
      OP_BUF:  alu_res = za;
      default: alu_res = '0;
    endcase
  end

  // One iteration of each multi-cycle algorithm; the final iteration is folded
  // into the edge that enters DONE so exactly WIDTH EXEC cycles are spent.
  always_comb begin
    mul_acc_nxt = acc + (mplier[0] ? mcand : '0);
    div_shift   = {rem, quot[WIDTH-1]};
    div_ge      = div_shift >= {1'b0, b_r};
    rem_nxt     = div_ge ? (div_shift[WIDTH-1:0] - b_r) : div_shift[WIDTH-1:0];
    quot_nxt    = {quot[WIDTH-2:0], div_ge};
  end

  always_comb begin
    last    = 1'b1;
    res_nxt = alu_res;
    case (op_r)
      OP_MUL: begin
        last    = (cnt == LAST);
        res_nxt = mul_acc_nxt;
      end
      OP_DIV: begin
        last    = (b_r == '0) || (cnt == LAST);
        res_nxt = (b_r == '0) ? {a_r, {WIDTH{1'b1}}} : {rem_nxt, quot_nxt};
      end
      default: begin
        last    = 1'b1;
        res_nxt = alu_res;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_r   <= OP_ADD;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      rem    <= '0;
      quot   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r   <= op_t'(command);
            a_r    <= A;
            b_r    <= B;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            acc    <= '0;
            rem    <= '0;
            quot   <= A;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (last) begin
            result <= res_nxt;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt    <= cnt + CW'(1);
            acc    <= mul_acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quot   <= quot_nxt;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign dout = oe ? result : {(2*WIDTH){1'bz}};

`ifdef ALU_SEQ_FLAGS_EN
  logic       carry_c, dbz_c;
  logic [2:0] flags_r;

  always_comb begin
    carry_c = 1'b0;
    dbz_c   = 1'b0;
    case (op_r)
      OP_ADD, OP_INC: carry_c = res_nxt[WIDTH];
      OP_SUB:         carry_c = a_r < b_r;
      OP_DEC:         carry_c = (a_r == '0);
      OP_DIV:         dbz_c   = (b_r == '0);
      default:        carry_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flags_r <= '0;
    else if (state == EXEC && last)
      flags_r <= {dbz_c, carry_c, (res_nxt == '0)};
  end

  assign flags = flags_r;
`else
  assign flags = 3'b000;
`endif

endmodule
